// File: rtl/rv_wb_pkg.sv
// Shared types for the writeback arbiter: widths, source ids and FIFO entry.
// Optional bypass feature is selected with RV_WB_BYPASS_EN.
package rv_wb_pkg;

    localparam int XLEN      = 64;
    localparam int REG_IDX_W = 5;

    typedef enum logic {
        SRC_ALU,
        SRC_LSU
    } wb_src_e;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_entry_t;

endpackage

// File: rtl/rv_wb_arbiter_if.sv
// Producer, regfile-write and hazard-query signals of the writeback arbiter.
// slave = arbiter view, master = surrounding pipeline view.
interface rv_wb_arbiter_if;
    import rv_wb_pkg::*;

    logic                 alu_valid;
    logic                 alu_ready;
    logic [REG_IDX_W-1:0] alu_rd;
    logic [XLEN-1:0]      alu_data;
    logic                 lsu_valid;
    logic                 lsu_ready;
    logic [REG_IDX_W-1:0] lsu_rd;
    logic [XLEN-1:0]      lsu_data;
    logic                 write;
    logic [REG_IDX_W-1:0] writeR;
    logic [XLEN-1:0]      write_data;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic                 rs1_pending;
    logic                 rs2_pending;
    logic                 rs1_byp_hit;
    logic                 rs2_byp_hit;
    logic [XLEN-1:0]      rs1_byp_data;
    logic [XLEN-1:0]      rs2_byp_data;
    logic                 busy;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  rs1, rs2,
        output alu_ready, lsu_ready,
        output write, writeR, write_data,
        output rs1_pending, rs2_pending,
        output rs1_byp_hit, rs2_byp_hit,
        output rs1_byp_data, rs2_byp_data,
        output busy
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output rs1, rs2,
        input  alu_ready, lsu_ready,
        input  write, writeR, write_data,
        input  rs1_pending, rs2_pending,
        input  rs1_byp_hit, rs2_byp_hit,
        input  rs1_byp_data, rs2_byp_data,
        input  busy
    );

endinterface

// File: rtl/rv_wb_fifo.sv
// Registered per-source result FIFO (no fall-through).
// Exposes every slot's rd and occupancy so hazard logic can scan it.
module rv_wb_fifo
    import rv_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic                             pop,
    input  wb_entry_t                        din,
    output wb_entry_t                        dout,
    output logic                             full,
    output logic                             empty,
    output logic [DEPTH-1:0][REG_IDX_W-1:0]  rd_vec,
    output logic [DEPTH-1:0]                 vld_vec
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        logic [AW-1:0] off;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = AW'(i) - rd_ptr_q;
            vld_vec[i] = ({1'b0, off} < cnt_q);
            rd_vec[i]  = mem_q[i].rd;
        end
    end

endmodule

// File: rtl/rv_wb_arbiter.sv
// Writeback stage: buffers ALU/LSU results, round-robin onto the regfile port,
// and reports pending destinations. RV_WB_BYPASS_EN adds an output-stage bypass.
module rv_wb_arbiter
    import rv_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    rv_wb_arbiter_if.slave  bus
);

    wb_entry_t alu_in, lsu_in, alu_out, lsu_out;
    logic      alu_push, lsu_push, alu_pop, lsu_pop;
    logic      alu_full, lsu_full, alu_empty, lsu_empty;

    logic [FIFO_DEPTH-1:0][REG_IDX_W-1:0] alu_rds, lsu_rds;
    logic [FIFO_DEPTH-1:0]                alu_vld, lsu_vld;

    logic                 write_q, write_d;
    logic [REG_IDX_W-1:0] writeR_q, writeR_d;
    logic [XLEN-1:0]      write_data_q, write_data_d;
    wb_src_e              last_grant_q, last_grant_d;

    assign alu_in   = '{rd: bus.alu_rd, data: bus.alu_data};
    assign lsu_in   = '{rd: bus.lsu_rd, data: bus.lsu_data};
    assign alu_push = bus.alu_valid && !alu_full;
    assign lsu_push = bus.lsu_valid && !lsu_full;

    rv_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk(clk), .rst(rst),
        .push(alu_push), .pop(alu_pop), .din(alu_in),
        .dout(alu_out), .full(alu_full), .empty(alu_empty),
        .rd_vec(alu_rds), .vld_vec(alu_vld)
    );

    rv_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_lsu_fifo (
        .clk(clk), .rst(rst),
        .push(lsu_push), .pop(lsu_pop), .din(lsu_in),
        .dout(lsu_out), .full(lsu_full), .empty(lsu_empty),
        .rd_vec(lsu_rds), .vld_vec(lsu_vld)
    );

    always_comb begin
        alu_pop      = 1'b0;
        lsu_pop      = 1'b0;
        write_d      = 1'b0;
        writeR_d     = writeR_q;
        write_data_d = write_data_q;
        last_grant_d = last_grant_q;
        unique case (1'b1)
            (!alu_empty && (lsu_empty || last_grant_q == SRC_LSU)): begin
                alu_pop      = 1'b1;
                write_d      = (alu_out.rd != '0);
                writeR_d     = alu_out.rd;
                write_data_d = alu_out.data;
                last_grant_d = SRC_ALU;
            end
            (!lsu_empty && (alu_empty || last_grant_q == SRC_ALU)): begin
                lsu_pop      = 1'b1;
                write_d      = (lsu_out.rd != '0);
                writeR_d     = lsu_out.rd;
                write_data_d = lsu_out.data;
                last_grant_d = SRC_LSU;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q      <= 1'b0;
            writeR_q     <= '0;
            write_data_q <= '0;
            last_grant_q <= SRC_LSU;
        end else begin
            write_q      <= write_d;
            writeR_q     <= writeR_d;
            write_data_q <= write_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    function automatic logic fifo_hit(
        input logic [REG_IDX_W-1:0]                 rs,
        input logic [FIFO_DEPTH-1:0][REG_IDX_W-1:0] rds,
        input logic [FIFO_DEPTH-1:0]                vld
    );
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            hit = hit | (vld[i] && rds[i] == rs);
        end
        return hit;
    endfunction

    logic rs1_fifo, rs2_fifo, rs1_out, rs2_out;

    assign rs1_fifo = fifo_hit(bus.rs1, alu_rds, alu_vld)
                    | fifo_hit(bus.rs1, lsu_rds, lsu_vld);
    assign rs2_fifo = fifo_hit(bus.rs2, alu_rds, alu_vld)
                    | fifo_hit(bus.rs2, lsu_rds, lsu_vld);

`ifdef RV_WB_BYPASS_EN
    // The regfile reads before it writes, so the output stage is forwarded.
    assign rs1_out          = 1'b0;
    assign rs2_out          = 1'b0;
    assign bus.rs1_byp_hit  = write_q && writeR_q == bus.rs1 && bus.rs1 != '0;
    assign bus.rs2_byp_hit  = write_q && writeR_q == bus.rs2 && bus.rs2 != '0;
    assign bus.rs1_byp_data = write_data_q;
    assign bus.rs2_byp_data = write_data_q;
`else
    assign rs1_out          = write_q && writeR_q == bus.rs1;
    assign rs2_out          = write_q && writeR_q == bus.rs2;
    assign bus.rs1_byp_hit  = 1'b0;
    assign bus.rs2_byp_hit  = 1'b0;
    assign bus.rs1_byp_data = '0;
    assign bus.rs2_byp_data = '0;
`endif

    assign bus.rs1_pending = (bus.rs1 != '0) && (rs1_fifo || rs1_out);
    assign bus.rs2_pending = (bus.rs2 != '0) && (rs2_fifo || rs2_out);

    assign bus.alu_ready  = !alu_full;
    assign bus.lsu_ready  = !lsu_full;
    assign bus.write      = write_q;
    assign bus.writeR     = writeR_q;
    assign bus.write_data = write_data_q;
    assign bus.busy       = !alu_empty || !lsu_empty || write_q;

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Bench for rv_wb_arbiter: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_rv_wb_arbiter;
    import rv_wb_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rv_wb_arbiter_if bus();

    rv_wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    ent_t        aq[$];
    ent_t        lq[$];
    wb_src_e     last;
    logic        exp_write;
    logic [4:0]  exp_wr;
    logic [63:0] exp_wd;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        aq.delete();
        lq.delete();
        last      = SRC_LSU;
        exp_write = 1'b0;
        exp_wr    = '0;
        exp_wd    = '0;
    endtask

    function automatic bit in_q(input logic [4:0] rs);
        foreach (aq[i]) if (aq[i].rd == rs) return 1'b1;
        foreach (lq[i]) if (lq[i].rd == rs) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_pend(input logic [4:0] rs);
        if (rs == 0) return 1'b0;
        if (in_q(rs)) return 1'b1;
`ifndef RV_WB_BYPASS_EN
        if (exp_write && exp_wr == rs) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic bit exp_byp(input logic [4:0] rs);
`ifdef RV_WB_BYPASS_EN
        return exp_write && exp_wr == rs && rs != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outputs();
        logic [63:0] bd;
`ifdef RV_WB_BYPASS_EN
        bd = exp_wd;
`else
        bd = '0;
`endif
        chk("write", bus.write, exp_write);
        chk("writeR", bus.writeR, exp_wr);
        chk("write_data", bus.write_data, exp_wd);
        chk("alu_ready", bus.alu_ready, aq.size() < DEPTH);
        chk("lsu_ready", bus.lsu_ready, lq.size() < DEPTH);
        chk("busy", bus.busy, aq.size() > 0 || lq.size() > 0 || exp_write);
        chk("rs1_pending", bus.rs1_pending, exp_pend(bus.rs1));
        chk("rs2_pending", bus.rs2_pending, exp_pend(bus.rs2));
        chk("rs1_byp_hit", bus.rs1_byp_hit, exp_byp(bus.rs1));
        chk("rs2_byp_hit", bus.rs2_byp_hit, exp_byp(bus.rs2));
        chk("rs1_byp_data", bus.rs1_byp_data, bd);
        chk("rs2_byp_data", bus.rs2_byp_data, bd);
    endtask

    task automatic model_step();
        bit   pa, pl, popped;
        ent_t e;
        pa     = bus.alu_valid && aq.size() < DEPTH;
        pl     = bus.lsu_valid && lq.size() < DEPTH;
        popped = 1'b1;
        if (aq.size() > 0 && lq.size() > 0) begin
            if (last == SRC_LSU) begin
                e = aq.pop_front(); last = SRC_ALU;
            end else begin
                e = lq.pop_front(); last = SRC_LSU;
            end
        end else if (aq.size() > 0) begin
            e = aq.pop_front(); last = SRC_ALU;
        end else if (lq.size() > 0) begin
            e = lq.pop_front(); last = SRC_LSU;
        end else begin
            popped = 1'b0;
        end
        if (popped) begin
            exp_write = (e.rd != 0);
            exp_wr    = e.rd;
            exp_wd    = e.data;
        end else begin
            exp_write = 1'b0;
        end
        if (pa) aq.push_back('{rd: bus.alu_rd, data: bus.alu_data});
        if (pl) lq.push_back('{rd: bus.lsu_rd, data: bus.lsu_data});
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] ard,
                         input logic [63:0] ad, input logic lv,
                         input logic [4:0] lrd, input logic [63:0] ld,
                         input logic [4:0] r1, input logic [4:0] r2);
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.lsu_valid = lv;
        bus.lsu_rd    = lrd;
        bus.lsu_data  = ld;
        bus.rs1       = r1;
        bus.rs2       = r2;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, bus.rs1, bus.rs2);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        bit seen_alu_full;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        chk("reset_write", bus.write, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_writeR", bus.writeR, 0);
        chk("reset_wdata", bus.write_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single ALU result
        drive(1, 5, 64'hA5, 0, 0, 0, 5, 0);
        cycle();
        idle(4);

        // simultaneous ALU and LSU, first tie goes to ALU
        drive(1, 3, 64'h11, 1, 4, 64'h22, 3, 4);
        cycle();
        idle(5);

        // sustained traffic on both sources fills the ALU FIFO
        seen_alu_full = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 5'(8 + i), 64'(100 + i), 1, 5'(20 + i),
                  64'(200 + i), 5'(8 + i), 5'(20 + i));
            cycle();
            if (!bus.alu_ready) seen_alu_full = 1'b1;
        end
        chk("alu_fifo_filled", seen_alu_full, 1);
        idle(10);

        // rd==0 result is dropped
        drive(1, 0, 64'hFF, 0, 0, 0, 0, 0);
        cycle();
        idle(4);
        chk("rd0_busy_drop", bus.busy, 0);

        // hazard query on an LSU destination
        drive(0, 0, 0, 1, 7, 64'hDEAD_BEEF, 7, 7);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 7, 7);
        for (int i = 0; i < 4; i++) cycle();

        // asynchronous reset with buffered results
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'(1 + i), 64'(300 + i), 1, 5'(10 + i),
                  64'(400 + i), 1, 10);
            cycle();
        end
        chk("pre_reset_busy", bus.busy, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 10);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_write", bus.write, 0);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_pend", bus.rs1_pending, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  {$urandom, $urandom},
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            cycle();
        end
        idle(8);
        chk("final_idle", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
